// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: shifts a valid-qualified bit stream through
// a window, counts pattern matches and ends a run on target, timeout or abort.
module seq_det_ctrl #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               x_valid,
  input  logic               x_i,
  output logic               det_o,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic               aborted,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StArm = 2'd1, StRun = 2'd2, StDone = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [TMO_W-1:0]   timeout_q, timeout_d;
  logic [MAX_LEN-1:0] window_q, window_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [TMO_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               det_q, det_d;
  logic               timed_out_q, timed_out_d;
  logic               aborted_q, aborted_d;
  logic               done_q, busy_q;

  logic [LEN_W-1:0]   eff_len;
  logic [CNT_W-1:0]   eff_target;
  logic [MAX_LEN-1:0] window_nxt, mask;
  logic [LEN_W:0]     fill_inc;
  logic               hit, tmo_hit;
  logic [CNT_W-1:0]   cnt_inc;

  // Effective values and match evaluation for the bit presented this cycle
  always_comb begin
    eff_len = len_q;
    if (len_q == '0) begin
      eff_len = LEN_W'(1);
    end else if (32'(len_q) > MAX_LEN) begin
      eff_len = LEN_W'(MAX_LEN);
    end
    eff_target = (target_q == '0) ? CNT_W'(1) : target_q;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(eff_len));
    end
    window_nxt = {window_q[MAX_LEN-2:0], x_i};
    fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
    hit        = x_valid && (fill_inc >= {1'b0, eff_len}) &&
                 (((window_nxt ^ pattern_q) & mask) == '0);
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    tmo_hit    = (timeout_q != '0) && (cyc_q == timeout_q - TMO_W'(1));
  end

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    target_d    = target_q;
    timeout_d   = timeout_q;
    window_d    = window_q;
    fill_d      = fill_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    det_d       = 1'b0;
    timed_out_d = timed_out_q;
    aborted_d   = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          len_d     = cfg_len;
          overlap_d = cfg_overlap;
          target_d  = cfg_target;
          timeout_d = cfg_timeout;
        end
        if (start) state_d = StArm;
      end
      StArm: begin
        window_d    = '0;
        fill_d      = '0;
        cyc_d       = '0;
        cnt_d       = '0;
        timed_out_d = 1'b0;
        aborted_d   = 1'b0;
        if (abort) begin
          state_d   = StDone;
          aborted_d = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        cyc_d = cyc_q + TMO_W'(1);
        if (abort) begin
          // A match coinciding with abort is dropped entirely
          state_d   = StDone;
          aborted_d = 1'b1;
        end else begin
          if (x_valid) begin
            window_d = window_nxt;
            fill_d   = (fill_inc >= {1'b0, eff_len}) ? eff_len : fill_inc[LEN_W-1:0];
            if (hit) begin
              det_d = 1'b1;
              cnt_d = cnt_inc;
              if (!overlap_q) fill_d = '0;
            end
          end
          if (hit && (cnt_inc >= eff_target)) begin
            state_d = StDone;
          end else if (tmo_hit) begin
            state_d     = StDone;
            timed_out_d = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pattern_q   <= '0;
      len_q       <= LEN_W'(1);
      overlap_q   <= 1'b0;
      target_q    <= CNT_W'(1);
      timeout_q   <= '0;
      window_q    <= '0;
      fill_q      <= '0;
      cyc_q       <= '0;
      cnt_q       <= '0;
      det_q       <= 1'b0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      overlap_q   <= overlap_d;
      target_q    <= target_d;
      timeout_q   <= timeout_d;
      window_q    <= window_d;
      fill_q      <= fill_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      det_q       <= det_d;
      timed_out_q <= timed_out_d;
      aborted_q   <= aborted_d;
      done_q      <= (state_d == StDone);
      busy_q      <= (state_d == StArm) || (state_d == StRun);
    end
  end

  assign det_o     = det_q;
  assign match_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign aborted   = aborted_q;
  assign state_o   = state_q;

endmodule
